// File: rtl/menu_scene_gen.sv
// menu_scene_gen: title-screen attract scene. Renders a row of N_CUBES
// isometric cubes and a sprite that hops between them. Each landing
// advances the destination cube's top-face colour through the palette.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   x_cnt, y_cnt    - current pixel row / column
//   jump_pulse      - one-cycle hop request (ignored while busy or landing)
//   auto_mode       - hop by itself after IDLE_WAIT idle clocks
//   menu_RGB        - pixel colour {R,G,B}, 2 clocks after x_cnt/y_cnt
//   jump_busy       - hop in progress
//   landed          - one-cycle pulse when a hop ends
//   cube_idx        - cube occupied, or departed from during a hop
//   all_done        - every top face at the last palette entry
module menu_scene_gen #(
  parameter int N_CUBES    = 4,
  parameter int NUM_COLORS = 5,
  parameter int X0         = 300,
  parameter int Y0         = 60,
  parameter int CUBE_PITCH = 200,
  parameter int XD         = 80,
  parameter int YD         = 100,
  parameter int XLEN       = 100,
  parameter int QB_H       = 40,
  parameter int QB_W       = 40,
  parameter int JUMP_H     = 40,
  parameter int STEP_DIV   = 131072,
  parameter int IDLE_WAIT  = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x_cnt,
  input  logic [9:0]  y_cnt,
  input  logic        jump_pulse,
  input  logic        auto_mode,
  output logic [23:0] menu_RGB,
  output logic        jump_busy,
  output logic        landed,
  output logic [2:0]  cube_idx,
  output logic        all_done
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RISE = 2'd1, S_SHIFT = 2'd2, S_FALL = 2'd3;

  localparam logic [23:0] C_BG  = {8'd146, 8'd165, 8'd216};
  localparam logic [23:0] C_FA  = {8'd86,  8'd169, 8'd152};
  localparam logic [23:0] C_FB  = {8'd49,  8'd70,  8'd70};
  localparam logic [23:0] C_SPR = {8'd216, 8'd95,  8'd2};

  localparam logic [10:0] CX   = 11'(X0 + XD);
  localparam logic [21:0] AREA = 22'(XD * YD);
  localparam logic [10:0] QX0  = 11'(X0 + XD - QB_H);
  localparam logic [9:0]  QY0  = 10'(Y0 + YD - QB_W / 2);

  localparam int PH_MAX = (JUMP_H > CUBE_PITCH) ? JUMP_H : CUBE_PITCH;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int SD_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int IW     = (IDLE_WAIT > 1) ? $clog2(IDLE_WAIT) : 1;

  function automatic logic [23:0] top_rgb(input logic [2:0] i);
    case (i)
      3'd0:    top_rgb = {8'd222, 8'd222, 8'd0};
      3'd1:    top_rgb = {8'd86,  8'd70,  8'd239};
      3'd2:    top_rgb = {8'd0,   8'd255, 8'd64};
      3'd3:    top_rgb = {8'd132, 8'd35,  8'd156};
      3'd4:    top_rgb = {8'd170, 8'd13,  8'd40};
      3'd5:    top_rgb = {8'd255, 8'd255, 8'd255};
      3'd6:    top_rgb = {8'd255, 8'd128, 8'd0};
      default: top_rgb = {8'd0,   8'd128, 8'd255};
    endcase
  endfunction

  // state
  logic [1:0]                  state_q, state_d;
  logic [SD_W-1:0]             step_q, step_d;
  logic [PH_W-1:0]             ph_q, ph_d;
  logic [IW-1:0]               idle_q, idle_d;
  logic [10:0]                 qx_q, qx_d;
  logic [9:0]                  qy_q, qy_d;
  logic                        dir_q, dir_d;       // 0 = +1, 1 = -1
  logic [2:0]                  tgt_q, tgt_d;
  logic [2:0]                  cube_q, cube_d;
  logic [N_CUBES-1:0][2:0]     col_q, col_d;
  logic                        landed_q, landed_d;
  logic                        all_done_q, all_done_d;
  logic                        spr_q, spr_d, fa_q, fa_d, fb_q, fb_d, top_q, top_d;
  logic [2:0]                  cidx_q, cidx_d;
  logic [23:0]                 rgb_q, rgb_d;

  // Row distance is shared by all cubes since every top vertex sits on X0.
  logic        x_below;
  logic [10:0] dx_abs;
  logic [21:0] dx_prod, fl_prod;
  assign x_below = x_cnt > CX;
  assign dx_abs  = x_below ? x_cnt - CX : CX - x_cnt;
  assign dx_prod = 22'(dx_abs) * 22'(YD);
  // The side floor is the lower top edge shifted down by XLEN: same
  // diamond test with dx reduced by XLEN, so no division is needed.
  assign fl_prod = (dx_abs > 11'(XLEN)) ? 22'(dx_abs - 11'(XLEN)) * 22'(YD) : '0;

  logic [N_CUBES-1:0] top_hit, fa_hit, fb_hit, done_vec;

  for (genvar k = 0; k < N_CUBES; k++) begin : g_cube
    localparam logic [9:0] YK = 10'(Y0 + k * CUBE_PITCH);
    localparam logic [9:0] YC = 10'(Y0 + k * CUBE_PITCH + YD);
    localparam logic [9:0] YE = 10'(Y0 + k * CUBE_PITCH + 2 * YD);
    logic [9:0]  dy;
    logic [21:0] ty;
    logic        side;
    assign dy         = (y_cnt >= YC) ? y_cnt - YC : YC - y_cnt;
    assign ty         = 22'(dy) * 22'(XD);
    assign top_hit[k] = (dx_prod + ty) <= AREA;
    assign side       = (y_cnt >= YK) && (y_cnt <= YE) && !top_hit[k] && x_below &&
                        ((fl_prod + ty) <= AREA);
    assign fa_hit[k]  = side && (y_cnt < YC);
    assign fb_hit[k]  = side && !(y_cnt < YC);
    assign done_vec[k] = col_q[k] == 3'(NUM_COLORS - 1);
  end

  // pixel pipeline
  always_comb begin
    spr_d  = (x_cnt >= qx_q) && (x_cnt < qx_q + 11'(QB_H)) &&
             (y_cnt >= qy_q) && (y_cnt < qy_q + 10'(QB_W));
    fa_d   = |fa_hit;
    fb_d   = |fb_hit;
    top_d  = |top_hit;
    cidx_d = '0;
    for (int k = 0; k < N_CUBES; k++)
      if (top_hit[k]) cidx_d = col_q[k];
    rgb_d = C_BG;
    if (spr_q)      rgb_d = C_SPR;
    else if (fb_q)  rgb_d = C_FB;
    else if (fa_q)  rgb_d = C_FA;
    else if (top_q) rgb_d = top_rgb(cidx_q);
  end

  // hop FSM
  logic tick;
  assign tick = (state_q != S_IDLE) && (step_q == SD_W'(STEP_DIV - 1));

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    ph_d       = ph_q;
    idle_d     = idle_q;
    qx_d       = qx_q;
    qy_d       = qy_q;
    dir_d      = dir_q;
    tgt_d      = tgt_q;
    cube_d     = cube_q;
    col_d      = col_q;
    landed_d   = 1'b0;
    all_done_d = &done_vec;
    if (state_q != S_IDLE) step_d = tick ? '0 : step_q + SD_W'(1);
    case (state_q)
      S_IDLE: begin
        idle_d = auto_mode ? idle_q + IW'(1) : '0;
        // Landing cycle still counts as part of the hop for requests.
        if (!landed_q && (jump_pulse || (auto_mode && idle_q == IW'(IDLE_WAIT - 1)))) begin
          idle_d  = '0;
          step_d  = '0;
          ph_d    = '0;
          state_d = S_RISE;
          if (!dir_q && cube_q == 3'(N_CUBES - 1)) begin
            dir_d = 1'b1;
            tgt_d = cube_q - 3'd1;
          end else if (dir_q && cube_q == 3'd0) begin
            dir_d = 1'b0;
            tgt_d = 3'd1;
          end else begin
            tgt_d = dir_q ? cube_q - 3'd1 : cube_q + 3'd1;
          end
        end
      end
      S_RISE: if (tick) begin
        qx_d = qx_q - 11'd1;
        if (ph_q == PH_W'(JUMP_H - 1)) begin ph_d = '0; state_d = S_SHIFT; end
        else ph_d = ph_q + PH_W'(1);
      end
      S_SHIFT: if (tick) begin
        qy_d = dir_q ? qy_q - 10'd1 : qy_q + 10'd1;
        if (ph_q == PH_W'(CUBE_PITCH - 1)) begin ph_d = '0; state_d = S_FALL; end
        else ph_d = ph_q + PH_W'(1);
      end
      default: if (tick) begin
        qx_d = qx_q + 11'd1;
        if (ph_q == PH_W'(JUMP_H - 1)) begin
          ph_d     = '0;
          state_d  = S_IDLE;
          landed_d = 1'b1;
          cube_d   = tgt_q;
          for (int k = 0; k < N_CUBES; k++)
            if (tgt_q == 3'(k))
              col_d[k] = (col_q[k] == 3'(NUM_COLORS - 1)) ? 3'd0 : col_q[k] + 3'd1;
        end else ph_d = ph_q + PH_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      ph_q       <= '0;
      idle_q     <= '0;
      qx_q       <= QX0;
      qy_q       <= QY0;
      dir_q      <= 1'b0;
      tgt_q      <= '0;
      cube_q     <= '0;
      col_q      <= '0;
      landed_q   <= 1'b0;
      all_done_q <= 1'b0;
      spr_q      <= 1'b0;
      fa_q       <= 1'b0;
      fb_q       <= 1'b0;
      top_q      <= 1'b0;
      cidx_q     <= '0;
      rgb_q      <= C_BG;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      ph_q       <= ph_d;
      idle_q     <= idle_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      dir_q      <= dir_d;
      tgt_q      <= tgt_d;
      cube_q     <= cube_d;
      col_q      <= col_d;
      landed_q   <= landed_d;
      all_done_q <= all_done_d;
      spr_q      <= spr_d;
      fa_q       <= fa_d;
      fb_q       <= fb_d;
      top_q      <= top_d;
      cidx_q     <= cidx_d;
      rgb_q      <= rgb_d;
    end
  end

  assign menu_RGB  = rgb_q;
  assign jump_busy = state_q != S_IDLE;
  assign landed    = landed_q;
  assign cube_idx  = cube_q;
  assign all_done  = all_done_q;
endmodule

// File: tb/tb_menu_scene_gen.sv
// Directed bench for menu_scene_gen with STEP_DIV=2, IDLE_WAIT=20.
// A hop lasts (2*40+200)*2 = 560 busy cycles.
module tb_menu_scene_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;
  logic        jump_pulse, auto_mode;
  logic [23:0] menu_RGB;
  logic        jump_busy, landed, all_done;
  logic [2:0]  cube_idx;

  menu_scene_gen #(.STEP_DIV(2), .IDLE_WAIT(20)) dut (
    .clk(clk), .reset(reset), .x_cnt(x_cnt), .y_cnt(y_cnt),
    .jump_pulse(jump_pulse), .auto_mode(auto_mode), .menu_RGB(menu_RGB),
    .jump_busy(jump_busy), .landed(landed), .cube_idx(cube_idx), .all_done(all_done)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] BG  = {8'd146, 8'd165, 8'd216};
  localparam logic [23:0] SPR = {8'd216, 8'd95,  8'd2};
  localparam logic [23:0] FA  = {8'd86,  8'd169, 8'd152};
  localparam logic [23:0] FB  = {8'd49,  8'd70,  8'd70};
  localparam logic [23:0] P0  = {8'd222, 8'd222, 8'd0};
  localparam logic [23:0] P1  = {8'd86,  8'd70,  8'd239};
  localparam logic [23:0] P2  = {8'd0,   8'd255, 8'd64};
  localparam logic [23:0] P4  = {8'd170, 8'd13,  8'd40};

  int checks = 0;
  int errors = 0;
  int land_total = 0;

  always @(negedge clk) if (landed) land_total++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [23:0] exp_v);
    x_cnt = 11'(x);
    y_cnt = 10'(y);
    repeat (2) @(negedge clk);
    check(tag, 32'(menu_RGB), 32'(exp_v));
  endtask

  // Entered on a negedge with jump_busy already high; returns on the
  // landing negedge (or on the extra-cycle checks when poke is set).
  task automatic wait_hop(input bit poke, output int busy_n);
    busy_n = 0;
    while (jump_busy && busy_n < 3000) begin
      busy_n++;
      jump_pulse = poke && (busy_n == 100);
      @(negedge clk);
    end
    jump_pulse = 1'b0;
    check("landed_on_fall", 32'(landed), 32'd1);
    if (poke) begin
      jump_pulse = 1'b1;
      @(negedge clk);
      jump_pulse = 1'b0;
      check("landed_one_cycle", 32'(landed), 32'd0);
      repeat (3) @(negedge clk);
      check("no_extra_hop", 32'(jump_busy), 32'd0);
    end
  endtask

  task automatic do_hop(input bit poke, output int busy_n);
    @(negedge clk);
    jump_pulse = 1'b1;
    @(negedge clk);
    jump_pulse = 1'b0;
    wait_hop(poke, busy_n);
  endtask

  initial begin
    int bn;
    int l0;
    int seq[3];
    seq = '{2, 3, 2};
    reset = 1'b0; x_cnt = '0; y_cnt = '0; jump_pulse = 1'b0; auto_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rgb", 32'(menu_RGB), 32'(BG));
    check("rst_busy", 32'(jump_busy), 32'd0);
    check("rst_landed", 32'(landed), 32'd0);
    check("rst_cube", 32'(cube_idx), 32'd0);
    check("rst_done", 32'(all_done), 32'd0);
    reset = 1'b1;

    pix("bg_pixel", 100, 100, BG);
    x_cnt = 11'd380; y_cnt = 10'd160;
    @(negedge clk);
    check("latency_1clk", 32'(menu_RGB), 32'(BG));
    @(negedge clk);
    check("latency_2clk", 32'(menu_RGB), 32'(P0));
    pix("sprite", 360, 160, SPR);
    pix("sprite_edge", 379, 160, SPR);
    pix("face_a", 430, 100, FA);
    pix("face_b", 430, 200, FB);
    pix("face_b_floor", 480, 160, FB);
    pix("below_floor", 570, 160, BG);

    // hop 1
    l0 = land_total;
    do_hop(1'b0, bn);
    check("hop1_busy_len", 32'(bn), 32'd560);
    check("hop1_cube", 32'(cube_idx), 32'd1);
    repeat (2) @(negedge clk);
    check("hop1_land_cnt", 32'(land_total - l0), 32'd1);
    pix("cube1_col1", 380, 360, P1);
    pix("cube0_no_sprite", 360, 160, P0);

    // hops 2..4: 2,3 then reverse to 2
    for (int i = 0; i < 3; i++) begin
      do_hop(1'b0, bn);
      check("seq_cube", 32'(cube_idx), 32'(seq[i]));
    end
    pix("cube2_col2", 380, 560, P2);

    // hops 5..12, then 13 is the fifth landing on cube 1
    for (int i = 0; i < 8; i++) do_hop(1'b0, bn);
    check("hop12_cube", 32'(cube_idx), 32'd0);
    pix("cube1_col4", 380, 360, P4);
    do_hop(1'b0, bn);
    check("hop13_cube", 32'(cube_idx), 32'd1);
    pix("cube1_wrap", 380, 360, P0);
    check("not_done", 32'(all_done), 32'd0);

    // auto hop after 20 idle cycles, with ignored requests
    @(negedge clk);
    auto_mode = 1'b1;
    repeat (19) @(negedge clk);
    check("auto_not_yet", 32'(jump_busy), 32'd0);
    @(negedge clk);
    check("auto_start", 32'(jump_busy), 32'd1);
    auto_mode = 1'b0;
    wait_hop(1'b1, bn);
    check("auto_busy_len", 32'(bn), 32'd560);
    check("auto_cube", 32'(cube_idx), 32'd2);

    // reset in the middle of SHIFT
    @(negedge clk);
    jump_pulse = 1'b1;
    @(negedge clk);
    jump_pulse = 1'b0;
    check("rst_hop_started", 32'(jump_busy), 32'd1);
    repeat (200) @(negedge clk);
    l0 = land_total;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(jump_busy), 32'd0);
    check("midrst_landed", 32'(landed), 32'd0);
    check("midrst_cube", 32'(cube_idx), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (600) @(negedge clk);
    check("midrst_idle", 32'(jump_busy), 32'd0);
    check("midrst_no_land", 32'(land_total - l0), 32'd0);
    pix("midrst_sprite", 360, 160, SPR);
    pix("midrst_c1", 380, 360, P0);
    pix("midrst_c2", 380, 560, P0);
    pix("midrst_c3", 380, 760, P0);

    // 26 hops from reset leave every cube at index 4
    for (int i = 0; i < 25; i++) do_hop(1'b0, bn);
    check("done_after_25", 32'(all_done), 32'd0);
    do_hop(1'b0, bn);
    check("done_delay", 32'(all_done), 32'd0);
    @(negedge clk);
    check("done_set", 32'(all_done), 32'd1);
    check("done_cube", 32'(cube_idx), 32'd2);
    pix("done_c0", 380, 160, P4);
    pix("done_c3", 380, 760, P4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
